// File: rtl/ines_loader.sv
// iNES image loader: parses the 16-byte header from a valid/ready byte stream, writes PRG/CHR
// bytes into the cartridge ROM arrays and publishes the decoded cartridge configuration.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_HDR   | consuming header bytes 0-15
// S_TRAIN | skipping 512-byte trainer
// S_PRG   | writing PRG ROM bytes
// S_CHR   | writing CHR ROM bytes
// S_DONE  | load complete, config valid
// S_ERR   | fault, error code held
module ines_loader #(
   parameter int PRG_ROM_DEPTH = 17,
   parameter int CHR_ROM_DEPTH = 15,
   parameter int PRG_RAM_DEPTH = 13
) (
   input  logic                     clk_cpu,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic                     prg_we,
   output logic [PRG_ROM_DEPTH-1:0] prg_waddr,
   output logic                     chr_we,
   output logic [CHR_ROM_DEPTH-1:0] chr_waddr,
   output logic [7:0]               wdata,
   output logic                     mirrorv,
   output logic                     chr_ram,
   output logic                     prg_ram,
   output logic [7:0]               mapper_id,
   output logic [PRG_ROM_DEPTH-1:0] prg_mask,
   output logic [CHR_ROM_DEPTH-1:0] chr_mask,
   output logic [PRG_RAM_DEPTH-1:0] prgram_mask,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               error
);

   localparam int CW0 = (PRG_ROM_DEPTH > CHR_ROM_DEPTH) ? PRG_ROM_DEPTH : CHR_ROM_DEPTH;
   localparam int CW  = (CW0 > 9) ? CW0 : 9;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_TRAIN, S_PRG, S_CHR, S_DONE, S_ERR
   } state_t;

   state_t          state, state_n;
   logic [3:0]      hdr_idx;
   logic [CW-1:0]   count;
   logic [CW-1:0]   prg_last, chr_last;
   logic [7:0]      b4, b5, b6, b7;
   logic [7:0]      magic;
   logic [31:0]     prg_bytes, chr_bytes;
   logic            accept, magic_bad, size_bad;

   // Smallest power-of-two multiple of the unit that covers n units, minus one.
   function automatic logic [31:0] pow2_mask(input logic [7:0] n, input int unit_log2);
      logic [31:0] m;
      m = (32'd1 << unit_log2) - 32'd1;
      for (int i = 0; i < 8; i++)
         if ((m + 32'd1) < (32'(n) << unit_log2))
            m = (m << 1) | 32'd1;
      return m;
   endfunction

   assign s_ready = ((state == S_HDR) || (state == S_TRAIN) ||
                     (state == S_PRG) || (state == S_CHR)) && !start;
   assign busy    = (state == S_HDR) || (state == S_TRAIN) ||
                    (state == S_PRG) || (state == S_CHR);
   assign done    = (state == S_DONE);
   assign accept  = s_valid && s_ready;

   always_comb begin
      magic = 8'h00;
      case (hdr_idx)
         4'd0:    magic = 8'h4E;
         4'd1:    magic = 8'h45;
         4'd2:    magic = 8'h53;
         4'd3:    magic = 8'h1A;
         default: magic = 8'h00;
      endcase
   end

   assign magic_bad = (hdr_idx < 4'd4) && (s_data != magic);
   assign prg_bytes = 32'(b4) << 14;
   assign chr_bytes = 32'(b5) << 13;
   assign size_bad  = (b4 == 8'd0) ||
                      (prg_bytes > (32'd1 << PRG_ROM_DEPTH)) ||
                      (chr_bytes > (32'd1 << CHR_ROM_DEPTH));

   always_ff @(posedge clk_cpu) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (start) begin
         state_n = S_HDR;
      end else begin
         case (state)
            S_HDR: if (accept) begin
               if (magic_bad)
                  state_n = S_ERR;
               else if (hdr_idx == 4'd15)
                  state_n = size_bad ? S_ERR : (b6[2] ? S_TRAIN : S_PRG);
            end
            S_TRAIN: if (accept && count == CW'(511)) state_n = S_PRG;
            S_PRG:   if (accept && count == prg_last) state_n = chr_ram ? S_DONE : S_CHR;
            S_CHR:   if (accept && count == chr_last) state_n = S_DONE;
            default: state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         hdr_idx     <= '0;
         count       <= '0;
         prg_last    <= '0;
         chr_last    <= '0;
         b4          <= '0;
         b5          <= '0;
         b6          <= '0;
         b7          <= '0;
         prg_we      <= 1'b0;
         chr_we      <= 1'b0;
         prg_waddr   <= '0;
         chr_waddr   <= '0;
         wdata       <= '0;
         mirrorv     <= 1'b0;
         chr_ram     <= 1'b0;
         prg_ram     <= 1'b0;
         mapper_id   <= '0;
         prg_mask    <= '0;
         chr_mask    <= '0;
         prgram_mask <= '0;
         error       <= '0;
      end else begin
         prg_we <= 1'b0;
         chr_we <= 1'b0;
         if (start) begin
            hdr_idx     <= '0;
            count       <= '0;
            b4          <= '0;
            b5          <= '0;
            b6          <= '0;
            b7          <= '0;
            mirrorv     <= 1'b0;
            chr_ram     <= 1'b0;
            prg_ram     <= 1'b0;
            mapper_id   <= '0;
            prg_mask    <= '0;
            chr_mask    <= '0;
            prgram_mask <= '0;
            error       <= '0;
         end else if (accept) begin
            case (state)
               S_HDR: begin
                  hdr_idx <= hdr_idx + 4'd1;
                  case (hdr_idx)
                     4'd4: b4 <= s_data;
                     4'd5: b5 <= s_data;
                     4'd6: b6 <= s_data;
                     4'd7: b7 <= s_data;
                     default: ;
                  endcase
                  if (magic_bad) begin
                     error <= 2'd1;
                  end else if (hdr_idx == 4'd15) begin
                     if (size_bad) begin
                        error <= 2'd2;
                     end else begin
                        mirrorv     <= b6[0];
                        prg_ram     <= b6[1];
                        chr_ram     <= (b5 == 8'd0);
                        mapper_id   <= {b7[7:4], b6[7:4]};
                        prg_mask    <= PRG_ROM_DEPTH'(pow2_mask(b4, 14));
                        chr_mask    <= CHR_ROM_DEPTH'(pow2_mask(b5, 13));
                        prgram_mask <= b6[1] ? '1 : '0;
                        prg_last    <= CW'(prg_bytes - 32'd1);
                        chr_last    <= CW'(chr_bytes - 32'd1);
                     end
                  end
               end
               S_TRAIN, S_PRG, S_CHR: begin
                  // Counter restarts at 0 whenever the byte ends a section.
                  count <= (state_n != state) ? '0 : count + CW'(1);
                  if (state == S_PRG) begin
                     prg_we    <= 1'b1;
                     prg_waddr <= count[PRG_ROM_DEPTH-1:0];
                     wdata     <= s_data;
                  end else if (state == S_CHR) begin
                     chr_we    <= 1'b1;
                     chr_waddr <= count[CHR_ROM_DEPTH-1:0];
                     wdata     <= s_data;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ines_loader.sv
// Scoreboard bench for ines_loader: expected writes are queued as bytes are handed over and
// popped as write strobes appear; control/config outputs are checked after each scenario.
module tb_ines_loader;
   localparam int PD = 15;
   localparam int CD = 15;
   localparam int RD = 13;

   logic          clk_cpu = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    s_data = 8'h00;
   logic          s_valid = 1'b0;
   logic          s_ready, prg_we, chr_we, mirrorv, chr_ram, prg_ram, busy, done;
   logic [PD-1:0] prg_waddr, prg_mask;
   logic [CD-1:0] chr_waddr, chr_mask;
   logic [RD-1:0] prgram_mask;
   logic [7:0]    wdata, mapper_id;
   logic [1:0]    error;

   ines_loader #(.PRG_ROM_DEPTH(PD), .CHR_ROM_DEPTH(CD), .PRG_RAM_DEPTH(RD)) dut (
      .clk_cpu(clk_cpu), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .prg_we(prg_we), .prg_waddr(prg_waddr), .chr_we(chr_we),
      .chr_waddr(chr_waddr), .wdata(wdata), .mirrorv(mirrorv), .chr_ram(chr_ram),
      .prg_ram(prg_ram), .mapper_id(mapper_id), .prg_mask(prg_mask), .chr_mask(chr_mask),
      .prgram_mask(prgram_mask), .busy(busy), .done(done), .error(error)
   );

   always #5 clk_cpu = ~clk_cpu;

   typedef struct packed {
      logic        chr;
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   int  prg_wr_cnt = 0;
   int  chr_wr_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest outstanding handshake.
   always @(negedge clk_cpu) begin
      wr_t e;
      if (prg_we && chr_we) check("both_we", {30'b0, prg_we, chr_we}, 32'h1);
      if (prg_we || chr_we) begin
         if (prg_we) prg_wr_cnt++;
         else        chr_wr_cnt++;
         if (exp_q.size() == 0) begin
            check("spurious_wr", {30'b0, prg_we, chr_we}, 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("wr", {7'b0, chr_we, chr_we ? 16'(chr_waddr) : 16'(prg_waddr), wdata},
                  {7'b0, e});
         end
      end
   end

   task automatic send(input logic [7:0] b, input bit gaps, input bit push, input wr_t e);
      bit hs;
      int cnt;
      if (gaps) begin
         while ($urandom_range(3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk_cpu); #1;
         end
      end
      s_data  = b;
      s_valid = 1'b1;
      cnt = 0;
      forever begin
         @(negedge clk_cpu);
         hs = s_ready;
         @(posedge clk_cpu); #1;
         if (hs) begin
            if (push) exp_q.push_back(e);
            break;
         end
         cnt++;
         if (cnt > 100) begin
            check("hs_timeout", {31'b0, s_ready}, 32'h1);
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] b6,
                           input logic [7:0] b7, input bit gaps);
      send(8'h4E, gaps, 1'b0, '0);
      send(8'h45, gaps, 1'b0, '0);
      send(8'h53, gaps, 1'b0, '0);
      send(8'h1A, gaps, 1'b0, '0);
      send(b4, gaps, 1'b0, '0);
      send(b5, gaps, 1'b0, '0);
      send(b6, gaps, 1'b0, '0);
      send(b7, gaps, 1'b0, '0);
      for (int i = 0; i < 8; i++) send(8'h00, gaps, 1'b0, '0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctl"}, {22'b0, s_ready, prg_we, chr_we, busy, done, mirrorv, chr_ram,
                            prg_ram, error}, 32'h0);
      check({tag, "_masks"}, {2'b0, prg_mask, chr_mask}, 32'h0);
      check({tag, "_cfg"}, {11'b0, mapper_id, prgram_mask}, 32'h0);
      check({tag, "_waddr"}, {9'b0, prg_waddr, wdata}, 32'h0);
      check({tag, "_caddr"}, {17'b0, chr_waddr}, 32'h0);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk_cpu); #1;
      start = 1'b0;
      check("start_state", {28'b0, busy, done, error}, 32'h8);
   endtask

   task automatic load(input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] b6,
                       input logic [7:0] b7, input bit gaps, input int rst_at);
      logic [7:0] d;
      send_hdr(b4, b5, b6, b7, gaps);
      if (b6[2])
         for (int i = 0; i < 512; i++) send(8'($urandom), gaps, 1'b0, '0);
      for (int i = 0; i < int'(b4) * 16384; i++) begin
         if (i == rst_at) begin
            s_data  = 8'($urandom);
            s_valid = 1'b1;
            rst     = 1'b1;
            @(posedge clk_cpu); #1;
            rst     = 1'b0;
            s_valid = 1'b0;
            return;
         end
         d = 8'($urandom);
         send(d, gaps, 1'b1, '{chr: 1'b0, addr: 16'(i), data: d});
      end
      for (int i = 0; i < int'(b5) * 8192; i++) begin
         d = 8'($urandom);
         send(d, gaps, 1'b1, '{chr: 1'b1, addr: 16'(i), data: d});
      end
   endtask

   initial begin
      int p0, c0;
      repeat (3) @(posedge clk_cpu);
      #1;
      check_reset_state("reset");
      rst = 1'b0;
      @(posedge clk_cpu); #1;
      check("idle_ready", {31'b0, s_ready}, 32'h0);

      // NROM-128, no gaps
      p0 = prg_wr_cnt; c0 = chr_wr_cnt;
      do_start();
      load(8'h01, 8'h01, 8'h01, 8'h00, 1'b0, -1);
      check("nrom_done", {28'b0, done, busy, s_ready, 1'b0} | {30'b0, error}, 32'h8);
      check("nrom_flags", {29'b0, mirrorv, chr_ram, prg_ram}, 32'h4);
      check("nrom_mapper", {24'b0, mapper_id}, 32'h0);
      check("nrom_prg_mask", {17'b0, prg_mask}, 32'h3FFF);
      check("nrom_chr_mask", {17'b0, chr_mask}, 32'h1FFF);
      check("nrom_pram_mask", {19'b0, prgram_mask}, 32'h0);
      s_data = 8'hAA; s_valid = 1'b1;
      repeat (3) @(posedge clk_cpu);
      #1;
      check("nrom_trailing_stall", {31'b0, s_ready}, 32'h0);
      s_valid = 1'b0;
      repeat (2) @(posedge clk_cpu);
      #1;
      check("nrom_prg_count", prg_wr_cnt - p0, 32'd16384);
      check("nrom_chr_count", chr_wr_cnt - c0, 32'd8192);
      check("nrom_queue_empty", exp_q.size(), 32'd0);

      // bad magic
      p0 = prg_wr_cnt; c0 = chr_wr_cnt;
      do_start();
      send(8'h4E, 1'b0, 1'b0, '0);
      send(8'h45, 1'b0, 1'b0, '0);
      send(8'h53, 1'b0, 1'b0, '0);
      send(8'h1B, 1'b0, 1'b0, '0);
      check("magic_err", {28'b0, s_ready, busy, error}, 32'h1);
      repeat (2) @(posedge clk_cpu);
      #1;
      check("magic_err_held", {30'b0, error}, 32'h1);
      check("magic_no_writes", (prg_wr_cnt - p0) + (chr_wr_cnt - c0), 32'd0);

      // size faults: PRG too big, PRG zero, PRG non-pow2 too big, CHR too big
      begin
         logic [7:0] sz_b4 [4] = '{8'h04, 8'h00, 8'h03, 8'h01};
         logic [7:0] sz_b5 [4] = '{8'h01, 8'h01, 8'h00, 8'h05};
         for (int k = 0; k < 4; k++) begin
            p0 = prg_wr_cnt; c0 = chr_wr_cnt;
            do_start();
            send_hdr(sz_b4[k], sz_b5[k], 8'h03, 8'h00, 1'b0);
            check($sformatf("size_err_%0d", k), {28'b0, s_ready, busy, error}, 32'h2);
            check($sformatf("size_cfg_%0d", k), {2'b0, prg_mask, chr_mask}, 32'h0);
            repeat (2) @(posedge clk_cpu);
            #1;
            check($sformatf("size_no_writes_%0d", k),
                  (prg_wr_cnt - p0) + (chr_wr_cnt - c0), 32'd0);
         end
      end

      // trainer, CHR RAM
      p0 = prg_wr_cnt; c0 = chr_wr_cnt;
      do_start();
      load(8'h01, 8'h00, 8'h04, 8'h00, 1'b0, -1);
      check("trn_done", {29'b0, done, busy, s_ready}, 32'h4);
      check("trn_flags", {29'b0, mirrorv, chr_ram, prg_ram}, 32'h2);
      check("trn_chr_mask", {17'b0, chr_mask}, 32'h1FFF);
      check("trn_prg_mask", {17'b0, prg_mask}, 32'h3FFF);
      repeat (2) @(posedge clk_cpu);
      #1;
      check("trn_prg_count", prg_wr_cnt - p0, 32'd16384);
      check("trn_chr_count", chr_wr_cnt - c0, 32'd0);
      check("trn_queue_empty", exp_q.size(), 32'd0);

      // mapper 0x41 with gaps; reset during PRG byte 100, then clean restart
      p0 = prg_wr_cnt;
      do_start();
      load(8'h01, 8'h00, 8'h13, 8'h40, 1'b1, 100);
      check_reset_state("midrst");
      repeat (2) @(posedge clk_cpu);
      #1;
      check("midrst_prg_count", prg_wr_cnt - p0, 32'd100);
      check("midrst_queue_empty", exp_q.size(), 32'd0);

      p0 = prg_wr_cnt; c0 = chr_wr_cnt;
      do_start();
      load(8'h01, 8'h00, 8'h13, 8'h40, 1'b1, -1);
      check("map_done", {28'b0, done, busy, error}, 32'h8);
      check("map_id", {24'b0, mapper_id}, 32'h41);
      check("map_flags", {29'b0, mirrorv, chr_ram, prg_ram}, 32'h7);
      check("map_pram_mask", {19'b0, prgram_mask}, 32'h1FFF);
      repeat (2) @(posedge clk_cpu);
      #1;
      check("map_prg_count", prg_wr_cnt - p0, 32'd16384);
      check("map_chr_count", chr_wr_cnt - c0, 32'd0);
      check("map_queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
